hack_data_memory: RTL

Data-memory subsystem directly downstream of the Hack CPU. It consumes the CPU's addressM/outM/writeM and returns inM combinationally. It decodes the Hack memory map into:
- 16K-word data RAM
- screen framebuffer window, forwarded to an external display port
- keyboard register backed by a small input FIFO
- LED register
- free-running cycle timer

---
 rtl/hack_data_memory.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hack_data_memory.sv
// Hack data-memory subsystem: decodes the CPU data bus into RAM, the screen
// window, a keyboard FIFO, an LED register and a free-running timer.
module hack_data_memory #(
  parameter int RAM_WORDS = 16384,
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_wdata,
  output logic        scr_we,
  input  logic [15:0] scr_rdata,
  input  logic [15:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic        kbd_overflow,
  output logic [15:0] led
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW     = $clog2(KBD_DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [16:0]   RAM_LIMIT  = 17'(RAM_WORDS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(KBD_DEPTH);
  localparam logic [15:0]   ADDR_KBD   = 16'h6000;
  localparam logic [15:0]   ADDR_LED   = 16'h6001;
  localparam logic [15:0]   ADDR_TIMER = 16'h6002;

  logic [15:0]   ram_q [RAM_WORDS];
  logic [15:0]   fifo_mem_q [KBD_DEPTH];

  logic [15:0]   led_q, led_d;
  logic [15:0]   timer_q, timer_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [RAM_AW-1:0] ram_idx;
  logic is_ram, is_scr, is_kbd, is_led, is_timer;
  logic fifo_empty, push, pop;

  // Address decode (full 16-bit compare; bit15 set never matches anything)
  always_comb begin
    ram_idx  = addressM[RAM_AW-1:0];
    is_ram   = ({1'b0, addressM} < RAM_LIMIT);
    is_scr   = (addressM[15:13] == 3'b010);
    is_kbd   = (addressM == ADDR_KBD);
    is_led   = (addressM == ADDR_LED);
    is_timer = (addressM == ADDR_TIMER);
  end

  // Screen port is a pass-through; the write enable is purely decode-driven
  always_comb begin
    scr_addr  = addressM[12:0];
    scr_wdata = outM;
    scr_we    = writeM & is_scr;
  end

  // FIFO handshake; a pop on an empty FIFO is simply dropped
  always_comb begin
    fifo_empty   = (count_q == '0);
    kbd_ready    = (count_q != FULL_COUNT);
    push         = kbd_valid & kbd_ready;
    pop          = writeM & is_kbd & ~fifo_empty;
    kbd_overflow = ovf_q;
    led          = led_q;
  end

  // Combinational read mux, no side effects
  always_comb begin
    inM = '0;
    if (is_ram) begin
      inM = ram_q[ram_idx];
    end else if (is_scr) begin
      inM = scr_rdata;
    end else if (is_kbd) begin
      inM = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    end else if (is_led) begin
      inM = led_q;
    end else if (is_timer) begin
      inM = timer_q;
    end
  end

  // Next-state for registers, timer write wins over the increment
  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q + 16'd1;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (kbd_valid & ~kbd_ready);
    if (writeM && is_led)   led_d   = outM;
    if (writeM && is_timer) timer_d = outM;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      timer_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      timer_q  <= timer_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (writeM && is_ram) ram_q[ram_idx] <= outM;
  end

  // FIFO storage; stale slots are harmless because the count gates reads
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= kbd_data;
  end

endmodule
